// File: rtl/sys_ctrl_pkg.sv
// Shared types and command codes for the sys_ctrl UART command controller.
package sys_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        RD_ADDR,
        RD_WAIT,
        TX_SEND
    } state_t;

    localparam logic [7:0] CMD_WR    = 8'hAA;
    localparam logic [7:0] CMD_RD    = 8'hBB;
    localparam logic [7:0] CMD_PING  = 8'hCC;
    localparam logic [7:0] PING_RESP = 8'h55;

    // States in which the inter-byte timeout counter runs.
    function automatic logic timed_state(input state_t s);
        return (s == WR_ADDR) || (s == WR_DATA) || (s == RD_ADDR) || (s == RD_WAIT);
    endfunction

endpackage

// File: rtl/sys_ctrl_timer.sv
// Inter-byte timeout counter; used by sys_ctrl only when SYS_CTRL_TIMEOUT_EN is defined.
module sys_ctrl_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic restart,
    output logic expired_c
);

    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CW-1:0] count;

    // An accepted byte wins over an expiry in the same cycle.
    assign expired_c = run && !restart && (count == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (!run || restart || expired_c) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/sys_ctrl.sv
// Byte-level command controller between the UART and the register file.
// Optional inter-byte timeout enabled by defining SYS_CTRL_TIMEOUT_EN.
module sys_ctrl
    import sys_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned ADDR_WIDTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] rx_p_data,
    input  logic                  rx_d_vld,
    output logic [ADDR_WIDTH-1:0] rf_addr,
    output logic [DATA_WIDTH-1:0] rf_wr_data,
    output logic                  rf_wr_en,
    output logic                  rf_rd_en,
    input  logic [DATA_WIDTH-1:0] rf_rd_data,
    input  logic                  rf_rd_data_vld,
    output logic [DATA_WIDTH-1:0] tx_p_data,
    output logic                  tx_d_vld,
    input  logic                  tx_busy,
    output logic                  frame_err
);

    state_t state;
    logic   timeout_c;

`ifdef SYS_CTRL_TIMEOUT_EN
    // Bytes dropped in RD_WAIT are not accepted, so they do not restart the count.
    sys_ctrl_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .run      (timed_state(state)),
        .restart  (rx_d_vld && (state != RD_WAIT)),
        .expired_c(timeout_c)
    );
`else
    assign timeout_c = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            rf_addr    <= '0;
            rf_wr_data <= '0;
            rf_wr_en   <= 1'b0;
            rf_rd_en   <= 1'b0;
            tx_p_data  <= '0;
            tx_d_vld   <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rf_wr_en  <= 1'b0;
            rf_rd_en  <= 1'b0;
            tx_d_vld  <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (rx_d_vld) begin
                        if (rx_p_data == DATA_WIDTH'(CMD_WR)) begin
                            state <= WR_ADDR;
                        end else if (rx_p_data == DATA_WIDTH'(CMD_RD)) begin
                            state <= RD_ADDR;
                        end else if (rx_p_data == DATA_WIDTH'(CMD_PING)) begin
                            tx_p_data <= DATA_WIDTH'(PING_RESP);
                            state     <= TX_SEND;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                end
                WR_ADDR: begin
                    if (rx_d_vld) begin
                        rf_addr <= rx_p_data[ADDR_WIDTH-1:0];
                        state   <= WR_DATA;
                    end else if (timeout_c) begin
                        frame_err <= 1'b1;
                        state     <= IDLE;
                    end
                end
                WR_DATA: begin
                    if (rx_d_vld) begin
                        rf_wr_data <= rx_p_data;
                        rf_wr_en   <= 1'b1;
                        state      <= IDLE;
                    end else if (timeout_c) begin
                        frame_err <= 1'b1;
                        state     <= IDLE;
                    end
                end
                RD_ADDR: begin
                    if (rx_d_vld) begin
                        rf_addr  <= rx_p_data[ADDR_WIDTH-1:0];
                        rf_rd_en <= 1'b1;
                        state    <= RD_WAIT;
                    end else if (timeout_c) begin
                        frame_err <= 1'b1;
                        state     <= IDLE;
                    end
                end
                RD_WAIT: begin
                    // A byte here is dropped even when read data arrives alongside it.
                    if (rx_d_vld) begin
                        frame_err <= 1'b1;
                    end
                    if (rf_rd_data_vld) begin
                        tx_p_data <= rf_rd_data;
                        state     <= TX_SEND;
                    end else if (timeout_c) begin
                        frame_err <= 1'b1;
                        state     <= IDLE;
                    end
                end
                TX_SEND: begin
                    if (rx_d_vld) begin
                        frame_err <= 1'b1;
                    end
                    if (!tx_busy) begin
                        tx_d_vld <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/sys_ctrl.md
# sys_ctrl

Byte-level command controller on the parallel side of the UART. Consumes received bytes from the UART receive path and decodes register-write, register-read and ping frames. Drives a register-file port and returns read data or ping responses through the UART transmit path with a valid/busy handshake. Sits between the UART block and the system register file.

## Interface
- DATA_WIDTH, 8, width of UART bytes and register data
- ADDR_WIDTH, 4, register-file address width; taken from the low bits of the address byte
- TIMEOUT_CYCLES, 4096, inter-byte timeout in CLK cycles; only used with SYS_CTRL_TIMEOUT_EN
- CLK  in  1  single clock for the block
- RST  in  1  asynchronous, active-high reset
- RX_P_DATA  in  DATA_WIDTH  received byte; valid only when RX_D_VLD=1
- RX_D_VLD  in  1  one-cycle pulse per received byte
- RF_ADDR  out  ADDR_WIDTH  register address; held from its address byte until the next address byte
- RF_WR_DATA  out  DATA_WIDTH  write data
- RF_WR_EN  out  1  one-cycle write strobe
- RF_RD_EN  out  1  one-cycle read strobe
- RF_RD_DATA  in  DATA_WIDTH  read data; valid only when RF_RD_DATA_VLD=1
- RF_RD_DATA_VLD  in  1  read-data valid pulse; arrives any number of cycles after RF_RD_EN
- TX_P_DATA  out  DATA_WIDTH  response byte to the UART transmitter
- TX_D_VLD  out  1  one-cycle request to the transmitter
- TX_BUSY  in  1  transmitter busy
- FRAME_ERR  out  1  one-cycle pulse on a protocol error

## Operation
- Frames:
  - write: CMD_WR, ADDR, DATA
  - read: CMD_RD, ADDR → one response byte carrying the register data
  - ping: CMD_PING → one response byte, PING_RESP
- FSM states: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_SEND.
- IDLE, on RX_D_VLD:
  - CMD_WR → WR_ADDR
  - CMD_RD → RD_ADDR
  - CMD_PING → load TX_P_DATA=PING_RESP, go to TX_SEND
  - any other byte → FRAME_ERR pulse, stay in IDLE
- WR_ADDR, on byte: RF_ADDR=byte[ADDR_WIDTH-1:0], go to WR_DATA.
- WR_DATA, on byte: RF_WR_DATA=byte, RF_WR_EN=1 for one cycle, go to IDLE.
- RD_ADDR, on byte: latch RF_ADDR, RF_RD_EN=1 for one cycle, go to RD_WAIT.
- RD_WAIT, on RF_RD_DATA_VLD: TX_P_DATA=RF_RD_DATA, go to TX_SEND.
- TX_SEND: when TX_BUSY=0, TX_D_VLD=1 for one cycle, then go to IDLE. While TX_BUSY=1, hold TX_P_DATA and keep waiting.
- A byte received in RD_WAIT or TX_SEND is dropped and raises a FRAME_ERR pulse; the state does not change.
- RF_RD_DATA_VLD in any state other than RD_WAIT is ignored.
- Address bits above ADDR_WIDTH-1 are ignored.

## Timing
- All outputs are registered and reset to 0. The FSM resets to IDLE.
- Reset asserted mid-frame aborts the frame. No strobe or TX_D_VLD is emitted after reset.
- Latencies:
  - RF_WR_EN and RF_RD_EN assert in the cycle after the RX_D_VLD that completes the address or data step.
  - TX_D_VLD asserts one cycle after entering TX_SEND, provided TX_BUSY=0.
  - Ping: TX_D_VLD asserts 2 cycles after RX_D_VLD when the transmitter is idle.
- FRAME_ERR is asserted in the cycle after the offending RX_D_VLD.
- Simultaneous events: RX_D_VLD together with RF_RD_DATA_VLD in RD_WAIT → the data is accepted, the byte is dropped, and FRAME_ERR pulses.

## Configuration
- Macro: SYS_CTRL_TIMEOUT_EN.
- Defined:
  - In WR_ADDR, WR_DATA, RD_ADDR and RD_WAIT a counter runs. It clears on entry to the state and on every accepted byte.
  - When it reaches TIMEOUT_CYCLES-1, the block pulses FRAME_ERR and returns to IDLE with no strobe issued.
  - TX_SEND never times out.
- Undefined: there is no counter, and the block waits indefinitely in each state.

## Structure
- Package sys_ctrl_pkg holds:
  - the state enum
  - CMD_WR=8'hAA, CMD_RD=8'hBB, CMD_PING=8'hCC, PING_RESP=8'h55
- Sub-module sys_ctrl_timer: the timeout counter, instantiated only under SYS_CTRL_TIMEOUT_EN.

## Test plan
- Write: send AA,03,5A → exactly one RF_WR_EN with RF_ADDR=3 and RF_WR_DATA=5A; no TX_D_VLD.
- Read: send BB,17; RF_RD_DATA_VLD with 3C arrives 5 cycles after RF_RD_EN → RF_ADDR=7; TX_D_VLD with TX_P_DATA=3C.
- Ping with TX_BUSY=1 for 20 cycles → TX_D_VLD with 55 issued in the first cycle after TX_BUSY falls; it fires only once.
- Unknown command 12, then AA,01,FF → FRAME_ERR pulses once; the write to address 1 completes normally.
- Reset asserted in WR_DATA, then byte 77 received → IDLE and FRAME_ERR; no RF_WR_EN.
- With SYS_CTRL_TIMEOUT_EN and TIMEOUT_CYCLES=16: send AA, then idle for 16 cycles → FRAME_ERR; the next BB,02 read then works.
